// File: rtl/ep_tx_arb_if.sv
// Bundle of request/grant, tag and TRN tx signals between the requesters, the
// arbiter and the PCIe core transmit port.
interface ep_tx_arb_if;
    logic [2:0]   req_ep;
    logic [2:0]   drv_ep;
    logic [2:0]   tag_inc;
    logic [2:0]   my_trn;
    logic [4:0]   tag_trn;
    logic [191:0] rq_trn_td;
    logic [23:0]  rq_trn_trem_n;
    logic [2:0]   rq_trn_tsof_n;
    logic [2:0]   rq_trn_teof_n;
    logic [2:0]   rq_trn_tsrc_rdy_n;
    logic [63:0]  trn_td;
    logic [7:0]   trn_trem_n;
    logic         trn_tsof_n;
    logic         trn_teof_n;
    logic         trn_tsrc_rdy_n;
    logic         err_drv;

    // Requester/core side.
    modport master (
        output req_ep, drv_ep, tag_inc,
        output rq_trn_td, rq_trn_trem_n, rq_trn_tsof_n, rq_trn_teof_n, rq_trn_tsrc_rdy_n,
        input  my_trn, tag_trn, err_drv,
        input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n
    );

    // Arbiter side.
    modport slave (
        input  req_ep, drv_ep, tag_inc,
        input  rq_trn_td, rq_trn_trem_n, rq_trn_tsof_n, rq_trn_teof_n, rq_trn_tsrc_rdy_n,
        output my_trn, tag_trn, err_drv,
        output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n
    );
endinterface

// File: rtl/ep_tx_arb.sv
// Three-way round-robin arbiter for the PCIe TRN transmit port with a shared
// non-posted tag counter, grant timeout and sticky driver-protocol error flag.
module ep_tx_arb #(
    parameter int unsigned GNT_TO   = 16,
    parameter logic [4:0]  TAG_INIT = 5'd0
) (
    input logic        clk,
    input logic        rst,
    ep_tx_arb_if.slave bus
);

    localparam int unsigned          TmoW   = $clog2(GNT_TO + 1);
    localparam logic [TmoW-1:0]      TmoMax = TmoW'(GNT_TO);

    typedef enum logic [1:0] {StIdle, StGnt, StDrv, StGap} state_e;

    state_e          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_q, last_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [4:0]      tag_q, tag_d;
    logic            err_q, err_d;

    logic            granted;
    logic [2:0]      my_trn_w;
    logic            own_drv, own_req, own_inc;
    logic [1:0]      cand1, cand2, pick;
    logic            pick_vld;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign granted  = (state_q == StGnt) || (state_q == StDrv);
    assign my_trn_w = granted ? (3'b001 << owner_q) : 3'b000;
    assign own_drv  = bus.drv_ep[owner_q];
    assign own_req  = bus.req_ep[owner_q];
    assign own_inc  = bus.tag_inc[owner_q];

    // Round-robin search starts just after the previous owner.
    always_comb begin
        cand1    = rr_next(last_q);
        cand2    = rr_next(cand1);
        pick     = last_q;
        pick_vld = |bus.req_ep;
        if (bus.req_ep[cand1]) begin
            pick = cand1;
        end else if (bus.req_ep[cand2]) begin
            pick = cand2;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        tag_d   = tag_q;
        err_d   = err_q | (|(bus.drv_ep & ~my_trn_w));

        if (granted && own_inc) begin
            tag_d = tag_q + 5'd1;
        end

        unique case (state_q)
            // The turnaround cycle also arbitrates, so back-to-back owners see a
            // single idle grant cycle between them.
            StIdle, StGap: begin
                if (pick_vld) begin
                    state_d = StGnt;
                    owner_d = pick;
                    last_d  = pick;
                    tmo_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StGnt: begin
                if (own_drv) begin
                    state_d = StDrv;
                end else if (!own_req) begin
                    state_d = StGap;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TmoMax) begin
                        state_d = StGap;
                    end
                end
            end
            StDrv: begin
                if (!own_drv) begin
                    state_d = StGap;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            tmo_q   <= '0;
            tag_q   <= TAG_INIT;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
        end
    end

    // Reset forces the idle TRN values immediately, even mid-packet.
    always_comb begin
        bus.trn_td         = 64'h0;
        bus.trn_trem_n     = 8'hFF;
        bus.trn_tsof_n     = 1'b1;
        bus.trn_teof_n     = 1'b1;
        bus.trn_tsrc_rdy_n = 1'b1;
        if (granted && own_drv && !rst) begin
            bus.trn_td         = bus.rq_trn_td[{owner_q, 6'd0} +: 64];
            bus.trn_trem_n     = bus.rq_trn_trem_n[{owner_q, 3'd0} +: 8];
            bus.trn_tsof_n     = bus.rq_trn_tsof_n[owner_q];
            bus.trn_teof_n     = bus.rq_trn_teof_n[owner_q];
            bus.trn_tsrc_rdy_n = bus.rq_trn_tsrc_rdy_n[owner_q];
        end
    end

    assign bus.my_trn  = my_trn_w;
    assign bus.tag_trn = tag_q;
    assign bus.err_drv = err_q;

endmodule
